mul_div_unit: RTL and testbench

Iterative HI/LO multiply/divide unit in the EX stage of the mipsel32 pipeline. It consumes the decoder's `is_mult`/`is_multu`/`is_div`/`is_divu`/`hi_wen`/`lo_wen` strobes together with the forwarded `rs_data`/`rt_data`. It holds the architectural HI and LO registers and raises `busy` to stall the pipeline while a multi-cycle operation is in flight. The `is_result_hi`/`is_result_lo` path reads `hi`/`lo` directly.

---
 rtl/mul_div_unit_if.sv | 31 +++
 rtl/mul_div_unit.sv | 182 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// EX-stage <-> HI/LO multiply/divide unit bundle.
// master = pipeline EX stage, slave = mul_div_unit.
interface mul_div_unit_if;
  logic        valid;
  logic        flush;
  logic        is_mult;
  logic        is_multu;
  logic        is_div;
  logic        is_divu;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output valid, flush,
    output is_mult, is_multu, is_div, is_divu,
    output hi_wen, lo_wen, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  valid, flush,
    input  is_mult, is_multu, is_div, is_divu,
    input  hi_wen, lo_wen, rs_data, rt_data,
    output busy, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (32-step shift-add / restoring divide).
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; division stays iterative.
module mul_div_unit #(
  parameter logic [31:0] HILO_RESET = 32'h0
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] op_q, op_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        any_op;
  logic        mul_op;
  logic        sgn;
  logic        issue;
  logic        start;
  logic        last;
  logic [31:0] abs_rs;
  logic [31:0] abs_rt;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [63:0] div_next;
  logic [63:0] prod_c;
  logic [31:0] quo_c;
  logic [31:0] rem_c;
`ifdef MDU_FAST_MUL_EN
  logic [63:0] fa;
  logic [63:0] fb;
  logic [63:0] fast_prod;
`endif

  always_comb begin
    any_op = bus.is_mult | bus.is_multu
           | bus.is_div | bus.is_divu;
    mul_op = bus.is_mult | bus.is_multu;
    sgn    = bus.is_mult | bus.is_div;
    issue  = bus.valid & ~bus.flush
           & (state_q == IDLE);
    start  = issue & any_op;
    abs_rs = (sgn & bus.rs_data[31])
           ? -bus.rs_data : bus.rs_data;
    abs_rt = (sgn & bus.rt_data[31])
           ? -bus.rt_data : bus.rt_data;
    last   = (cnt_q == 5'd31);

    // Product register: upper half accumulates, multiplier shifts out of bit 0.
    mul_sum  = {1'b0, acc_q[63:32]}
             + (acc_q[0] ? {1'b0, op_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Remainder in upper half, dividend/quotient bits in lower half.
    div_trial = acc_q[63:31] - {1'b0, op_q};
    div_next  = div_trial[32]
              ? {acc_q[62:0], 1'b0}
              : {div_trial[31:0], acc_q[30:0], 1'b1};

    prod_c = neg_q  ? -mul_next : mul_next;
    quo_c  = neg_q  ? -div_next[31:0]  : div_next[31:0];
    rem_c  = rneg_q ? -div_next[63:32] : div_next[63:32];

`ifdef MDU_FAST_MUL_EN
    fa = (sgn ? {{32{bus.rs_data[31]}}, bus.rs_data}
              : {32'b0, bus.rs_data});
    fb = (sgn ? {{32{bus.rt_data[31]}}, bus.rt_data}
              : {32'b0, bus.rt_data});
    fast_prod = fa * fb;
    bus.busy = (start & ~mul_op)
             | (state_q == MUL) | (state_q == DIV);
`else
    bus.busy = start
             | (state_q == MUL) | (state_q == DIV);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (issue & bus.hi_wen) hi_d = bus.rs_data;
        if (issue & bus.lo_wen) lo_d = bus.rs_data;
        if (start) begin
          cnt_d  = 5'd0;
          neg_d  = sgn & (bus.rs_data[31] ^ bus.rt_data[31]);
          rneg_d = sgn & bus.rs_data[31];
          dz_d   = (bus.rt_data == 32'd0);
          if (mul_op) begin
`ifdef MDU_FAST_MUL_EN
            {hi_d, lo_d} = fast_prod;
`else
            state_d = MUL;
            acc_d   = {32'b0, abs_rt};
            op_d    = abs_rs;
`endif
          end else begin
            state_d = DIV;
            acc_d   = {32'b0, abs_rs};
            op_d    = abs_rt;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          {hi_d, lo_d} = prod_c;
          state_d      = DONE;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          if (!dz_q) begin
            hi_d = rem_c;
            lo_d = quo_c;
          end
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      op_q    <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= HILO_RESET;
      lo_q    <= HILO_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized bench for mul_div_unit against a plain-arithmetic HI/LO model.
// Honours MDU_FAST_MUL_EN for expected multiply latency.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_unit_if bus();

  mul_div_unit #(.HILO_RESET(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mhi = 32'h0;
  logic [31:0] mlo = 32'h0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    bus.valid    = 1'b0;
    bus.flush    = 1'b0;
    bus.is_mult  = 1'b0;
    bus.is_multu = 1'b0;
    bus.is_div   = 1'b0;
    bus.is_divu  = 1'b0;
    bus.hi_wen   = 1'b0;
    bus.lo_wen   = 1'b0;
    bus.rs_data  = 32'h0;
    bus.rt_data  = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 mult, 1 multu, 2 div, 3 divu
  task automatic drive(input int kind,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.valid    = 1'b1;
    bus.is_mult  = (kind == 0);
    bus.is_multu = (kind == 1);
    bus.is_div   = (kind == 2);
    bus.is_divu  = (kind == 3);
    bus.rs_data  = a;
    bus.rt_data  = b;
  endtask

  task automatic model(input int kind,
                       input logic [31:0] a,
                       input logic [31:0] b);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (kind)
      0: begin
        sp = sa * sb;
        {mhi, mlo} = sp;
      end
      1: begin
        up = ua * ub;
        {mhi, mlo} = up;
      end
      2: if (b != 32'h0) begin
        sq = sa / sb;
        sr = sa % sb;
        mlo = sq[31:0];
        mhi = sr[31:0];
      end
      default: if (b != 32'h0) begin
        mlo = 32'(ua / ub);
        mhi = 32'(ua % ub);
      end
    endcase
  endtask

  task automatic run_op(input int kind,
                        input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    bit fast;
    fast = 1'b0;
`ifdef MDU_FAST_MUL_EN
    fast = (kind < 2);
`endif
    drive(kind, a, b);
    #1;
    if (fast) begin
      chk("fast_busy", bus.busy, 0);
      step();
      quiet();
      model(kind, a, b);
      chk("fast_hi", bus.hi, mhi);
      chk("fast_lo", bus.lo, mlo);
      return;
    end
    chk("issue_busy", bus.busy, 1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      #1;
      if (!bus.busy) break;
      n++;
      if (n == 17) chk("hold_hi", bus.hi, mhi);
    end
    chk("busy_len", n, 33);
    model(kind, a, b);
    chk("op_hi", bus.hi, mhi);
    chk("op_lo", bus.lo, mlo);
    quiet();
    step();
  endtask

  task automatic mt(input bit h, input bit l,
                    input logic [31:0] d);
    bus.valid   = 1'b1;
    bus.hi_wen  = h;
    bus.lo_wen  = l;
    bus.rs_data = d;
    step();
    quiet();
    if (h) mhi = d;
    if (l) mlo = d;
    chk("mt_hi", bus.hi, mhi);
    chk("mt_lo", bus.lo, mlo);
  endtask

  task automatic abort(input bit use_reset);
    drive(2, 32'h1234_5678, 32'h0000_0123);
    for (int i = 0; i < 11; i++) step();
    if (use_reset) reset = 1'b1;
    else bus.flush = 1'b1;
    #1;
    if (!use_reset) chk("flush_busy", bus.busy, 1);
    step();
    quiet();
    reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    if (use_reset) begin
      mhi = 32'h0;
      mlo = 32'h0;
    end
    chk("abort_hi", bus.hi, mhi);
    chk("abort_lo", bus.lo, mlo);
    step();
    run_op(3, 32'd1000, 32'd33);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h0;
      3: v = 32'(1 + $urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    quiet();
    reset = 1'b1;
    step();
    drive(3, 32'd100, 32'd7);
    step();
    reset = 1'b0;
    quiet();
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    step();

    run_op(3, 32'd100, 32'd7);
    run_op(2, 32'hFFFF_FFF9, 32'd2);
    run_op(2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(0, 32'hFFFF_FFFF, 32'd2);
    run_op(1, 32'hFFFF_FFFF, 32'd2);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    run_op(3, 32'd55, 32'd0);
    abort(1'b0);
    abort(1'b1);

    for (int k = 0; k < 30; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) run_op(r % 4, pick(), pick());
      else mt(r[0], ~r[0], $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
